// File: rtl/fetch_unit.sv
// Instruction fetch stage for the multi-cycle RV32I core: owns the PC, fetches
// one word per instruction over a ready handshake, holds it for EXEC, selects
// the next PC and halts with a sticky fault on misaligned targets or
// non-32-bit encodings.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  input  logic                  PCSel,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [31:0]           inst,
  output logic [4:0]            opcode_eff,
  output logic [2:0]            funct3,
  output logic                  inst_valid,
  output logic                  fetch_fault,
  output logic [1:0]            fault_cause,
  output logic [31:0]           instret
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] target;
  logic [31:0]           inst_nxt;
  logic [31:0]           instret_nxt;
  logic [1:0]            cause_nxt;

  // Strobes and decoder fields are pure wiring of registered state
  assign imem_req    = (state == FETCH);
  assign inst_valid  = (state == EXEC);
  assign fetch_fault = (state == FAULT);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + ADDR_WIDTH'(4);
  assign opcode_eff  = inst[6:2];
  assign funct3      = inst[14:12];

  // Candidate next PC; bit 0 of a jump target is always dropped (JALR rule)
  assign target = PCSel ? {alu_result[ADDR_WIDTH-1:1], 1'b0} : pc_plus4;

  // State, PC, instruction, retire counter and fault cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst        <= NOP_INST;
      instret     <= '0;
      fault_cause <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst        <= inst_nxt;
      instret     <= instret_nxt;
      fault_cause <= cause_nxt;
    end
  end

  // Next-state and next-register values; everything holds by default
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst;
    instret_nxt = instret;
    cause_nxt   = fault_cause;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem_ready) begin
          if (imem_rdata[1:0] == 2'b11) begin
            inst_nxt  = imem_rdata;
            state_nxt = EXEC;
          end else begin
            cause_nxt = 2'b10;
            state_nxt = FAULT;
          end
        end
      end
      EXEC: begin
        if (!stall) begin
          if (target[1:0] == 2'b00) begin
            pc_nxt      = target;
            instret_nxt = instret + 32'd1;
            state_nxt   = FETCH;
          end else begin
            cause_nxt = 2'b01;
            state_nxt = FAULT;
          end
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of instruction records driven
// through a memory model, expected {pc, inst} pushed to a scoreboard at the
// handshake and popped when the DUT enters EXEC, plus hand-written corner cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        PCSel = 1'b0;
  logic [31:0] alu_result = '0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] inst;
  logic [4:0]  opcode_eff;
  logic [2:0]  funct3;
  logic        inst_valid;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INST  (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCSel      (PCSel),
    .alu_result (alu_result),
    .stall      (stall),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst       (inst),
    .opcode_eff (opcode_eff),
    .funct3     (funct3),
    .inst_valid (inst_valid),
    .fetch_fault(fetch_fault),
    .fault_cause(fault_cause),
    .instret    (instret)
  );

  typedef struct {
    int unsigned wait_n;
    logic [31:0] rdata;
    int unsigned stall_n;
    logic        pcsel;
    logic [31:0] alu;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t        vecs[9];
  exp_t        sb[$];
  logic [31:0] model_pc;
  logic [31:0] model_instret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    stall = 1'b0;
    PCSel = 1'b0;
    alu_result = '0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_iv", inst_valid, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_cause", fault_cause, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_instret", instret, 0);
    rst_n = 1'b1;
    #1 check("idle_req", imem_req, 0);
    @(negedge clk);
    model_pc = '0;
    model_instret = '0;
    sb.delete();
  endtask

  initial begin
    exp_t        e;
    logic [31:0] nxt;
    logic        faulted;

    // wait, rdata, stall, PCSel, alu_result
    vecs[0] = '{0, 32'h0010_0093, 0, 1'b0, 32'h0};
    vecs[1] = '{0, 32'h0020_0113, 0, 1'b0, 32'h0};
    vecs[2] = '{0, 32'h0030_0193, 0, 1'b0, 32'h0};
    vecs[3] = '{3, 32'h0041_2203, 2, 1'b1, 32'h0000_0101};
    vecs[4] = '{0, 32'h1040_006F, 0, 1'b1, 32'h0000_0205};
    vecs[5] = '{1, 32'h0000_0013, 0, 1'b1, 32'hFFFF_FFFC};
    vecs[6] = '{0, 32'h0070_0393, 0, 1'b0, 32'h0};
    vecs[7] = '{0, 32'h0400_0067, 0, 1'b1, 32'h0000_0040};
    vecs[8] = '{0, 32'h0000_0463, 0, 1'b1, 32'h0000_0082};

    do_reset();
    faulted = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, model_pc);
      check("fetch_iv", inst_valid, 0);
      for (int w = 0; w < int'(vecs[i].wait_n); w++) begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        @(negedge clk);
        check("wait_req", imem_req, 1);
        check("wait_addr", imem_addr, model_pc);
      end
      imem_ready = 1'b1;
      imem_rdata = vecs[i].rdata;
      sb.push_back('{model_pc, vecs[i].rdata});
      @(negedge clk);
      // memory keeps offering junk: must be ignored outside FETCH
      imem_ready = (vecs[i].stall_n != 0);
      imem_rdata = 32'hDEAD_BEEF;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_empty: got 0 entries expected 1");
        e = '{32'hx, 32'hx};
      end else begin
        e = sb.pop_front();
      end
      check("exec_iv", inst_valid, 1);
      check("exec_req", imem_req, 0);
      check("exec_pc", pc, e.pc);
      check("exec_inst", inst, e.inst);
      check("exec_opc", opcode_eff, {27'b0, e.inst[6:2]});
      check("exec_f3", funct3, {29'b0, e.inst[14:12]});
      check("exec_pc4", pc_plus4, e.pc + 32'd4);
      check("exec_instret", instret, model_instret);
      for (int s = 0; s < int'(vecs[i].stall_n); s++) begin
        stall = 1'b1;
        PCSel = 1'b1;
        alu_result = 32'h0000_0002;
        @(negedge clk);
        check("stall_iv", inst_valid, 1);
        check("stall_inst", inst, e.inst);
        check("stall_pc", pc, e.pc);
        check("stall_instret", instret, model_instret);
      end
      imem_ready = 1'b0;
      stall = 1'b0;
      PCSel = vecs[i].pcsel;
      alu_result = vecs[i].alu;
      nxt = vecs[i].pcsel ? {vecs[i].alu[31:1], 1'b0} : model_pc + 32'd4;
      @(negedge clk);
      PCSel = 1'b0;
      alu_result = 32'h0000_0003;
      if (nxt[1:0] == 2'b00) begin
        model_pc = nxt;
        model_instret = model_instret + 32'd1;
        check("next_fault", fetch_fault, 0);
        check("next_instret", instret, model_instret);
      end else begin
        faulted = 1'b1;
        check("mis_fault", fetch_fault, 1);
        check("mis_cause", fault_cause, 32'd1);
        check("mis_pc", pc, model_pc);
        check("mis_instret", instret, model_instret);
        check("mis_inst", inst, e.inst);
        break;
      end
    end
    check("table_faulted", faulted, 1);
    check("table_instret", model_instret, 32'd8);
    repeat (3) begin
      imem_ready = 1'b1;
      imem_rdata = 32'h0000_0013;
      @(negedge clk);
      check("fault_req", imem_req, 0);
      check("fault_iv", inst_valid, 0);
      check("fault_sticky", fetch_fault, 1);
      check("fault_pc", pc, 32'h0000_0040);
    end

    // Illegal (compressed) encoding
    do_reset();
    check("ill_req", imem_req, 1);
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_4501;
    @(negedge clk);
    imem_rdata = 32'h0000_0013;
    check("ill_fault", fetch_fault, 1);
    check("ill_cause", fault_cause, 32'd2);
    check("ill_inst", inst, 32'h0000_0013);
    check("ill_pc", pc, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("ill_iv", inst_valid, 0);
      check("ill_req_low", imem_req, 0);
    end

    // Asynchronous reset in the middle of a FETCH
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0293;
    @(negedge clk);
    imem_ready = 1'b0;
    check("ar_exec_iv", inst_valid, 1);
    @(negedge clk);
    check("ar_fetch_req", imem_req, 1);
    check("ar_fetch_pc", pc, 32'h4);
    check("ar_instret", instret, 1);
    check("ar_inst", inst, 32'h0050_0293);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req", imem_req, 0);
    check("ar_pc", pc, 32'h0);
    check("ar_inst_rst", inst, 32'h0000_0013);
    check("ar_instret_rst", instret, 0);
    check("ar_iv", inst_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the multi-cycle RV32I core. Owns the program counter, fetches one instruction word per instruction from instruction memory over a ready handshake, and holds it stable for the execute cycle. Drives `opcode_eff`/`funct3` into the main decoder, and consumes the decoder's `PCSel` plus the ALU result to select the next PC. Detects misaligned targets and non-32-bit encodings, then halts with a sticky fault.

## Interface
- `ADDR_WIDTH`, 32, PC / instruction-memory address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, instruction register reset value (`addi x0,x0,0`).
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_addr`  out  ADDR_WIDTH  fetch address; equals `pc`.
- `imem_ready`  in  1  `imem_rdata` valid this cycle; ignored outside FETCH.
- `imem_rdata`  in  32  instruction word.
- `PCSel`  in  1  from main decoder; 0 = PC+4, 1 = ALU target.
- `alu_result`  in  ADDR_WIDTH  branch/jump target from ALU.
- `stall`  in  1  hold EXEC (multi-cycle data-memory access).
- `pc`  out  ADDR_WIDTH  PC of the held instruction.
- `pc_plus4`  out  ADDR_WIDTH  `pc + 4`, modulo 2^ADDR_WIDTH (for WBSel = 2).
- `inst`  out  32  held instruction register.
- `opcode_eff`  out  5  `inst[6:2]`.
- `funct3`  out  3  `inst[14:12]`.
- `inst_valid`  out  1  high in EXEC; register-file and memory writes are qualified by it.
- `fetch_fault`  out  1  sticky fault flag.
- `fault_cause`  out  2  01 = misaligned target, 10 = illegal encoding, 00 = none.
- `instret`  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, EXEC, FAULT.
- Reset: IDLE, `pc`=RESET_PC, `inst`=NOP_INST, `instret`=0, `fault_cause`=00.
  - All strobes/flags are 0: `imem_req`, `inst_valid`, `fetch_fault`.
- IDLE: unconditional move to FETCH on the next edge.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`, held stable until `imem_ready`.
  - On `imem_ready`=1, if `imem_rdata[1:0]`==2'b11: capture `imem_rdata` into `inst`, go to EXEC.
  - On `imem_ready`=1, if `imem_rdata[1:0]`!=2'b11: go to FAULT, `fault_cause`=10, `inst` unchanged.
- EXEC:
  - `inst_valid`=1; decoder evaluates the held `inst`.
  - `stall`=1: stay in EXEC; `pc`, `inst`, `instret` are held.
  - `stall`=0: `next_pc` = `PCSel` ? {`alu_result`[ADDR_WIDTH-1:1],1'b0} : `pc`+4. Bit 0 is cleared per JALR semantics.
    - If `next_pc[1:0]`==00: `pc`<=`next_pc`, `instret`<=`instret`+1, go to FETCH.
    - Otherwise: go to FAULT, `fault_cause`=01, `pc` holds the faulting instruction's PC, `instret` not incremented.
- FAULT:
  - Terminal until `rst_n` asserts.
  - `fetch_fault`=1; `imem_req`=0 and `inst_valid`=0.
  - `pc` and `inst` frozen for debug.
- `instret` wraps from 32'hFFFF_FFFF to 0. PC+4 wraps from 32'hFFFF_FFFC to 0 without fault.
- `PCSel` and `alu_result` are sampled only in EXEC with `stall`=0.

## Timing
- `opcode_eff`, `funct3`, `pc`, `pc_plus4`, `inst` are registered or pure wiring of registered state. No combinational path from `imem_rdata` to them.
- `imem_req` and `inst_valid` decode from the state register only. `fetch_fault` equals (state==FAULT).
- Zero-wait memory (`imem_ready` high in the first FETCH cycle): 2 cycles per instruction (FETCH, EXEC).
- N wait cycles add N cycles. Each stall cycle adds 1.
- First `imem_req` appears in the 2nd cycle after `rst_n` deasserts.
- Reset mid-FETCH or mid-EXEC: outputs go to reset values immediately (asynchronous). The pending fetch is abandoned and the memory must tolerate a dropped request.
- `inst_valid` is never high in the same cycle as `imem_req`.

## Test plan
- **Sequential fetch:** reset, zero-wait memory returning `addi` words -> `imem_addr` 0,4,8,12 on alternating cycles; `instret`=3 after the third EXEC; `inst_valid` pulses every 2 cycles.
- **Wait states and stall:** `imem_ready` delayed 3 cycles, then `stall`=1 for 2 EXEC cycles -> `imem_addr` held for 4 FETCH cycles; `inst` captured once; `inst_valid` high 3 cycles; `instret` +1.
- **Taken jump:** EXEC at `pc`=0x100 with `PCSel`=1, `alu_result`=0x0000_0205 -> next `imem_addr`=0x204.
- **Misaligned target:** EXEC at `pc`=0x40 with `PCSel`=1, `alu_result`=0x0000_0082 -> FAULT; `fault_cause`=01; `pc`=0x40; `instret` unchanged; `imem_req` stays 0.
- **Illegal encoding:** `imem_rdata`=0x0000_4501 (compressed) -> FAULT; `fault_cause`=10; `inst` keeps its prior value; `inst_valid` never asserts.
- **PC wrap and async reset:** `pc`=0xFFFF_FFFC, `PCSel`=0 -> `pc`=0 with no fault. Then drop `rst_n` mid-FETCH -> `imem_req`=0 in the same cycle; `pc`=RESET_PC; `inst`=0x0000_0013.
